// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the unified memory arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;

  logic              ma_req;
  logic              ma_we;
  logic [ADDR_W-1:0] ma_addr;
  logic [31:0]       ma_wdata;
  logic [3:0]        ma_wstrb;
  logic              ma_ready;
  logic [31:0]       ma_rdata;

  logic              bus_err;
  logic              stall_if;
  logic              stall_ma;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, ma_wstrb, mem_rdata, mem_ready,
    output if_ready, if_rdata, ma_ready, ma_rdata, bus_err, stall_if, stall_ma,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, ma_wstrb, mem_rdata, mem_ready,
    input  if_ready, if_rdata, ma_ready, ma_rdata, bus_err, stall_if, stall_ma,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (MA): MA-priority with a
// bounded IF starvation streak, one access in flight, and a watchdog that aborts hung accesses.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MA_BURST_MAX = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus_io
);
  localparam int ST_W = $clog2(MA_BURST_MAX + 1);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(MA_BURST_MAX);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MA} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              if_ready_q, if_ready_d;
  logic              ma_ready_q, ma_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       ma_rdata_q, ma_rdata_d;
  logic [ST_W-1:0]   streak_q, streak_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic if_elig, ma_elig, wd_expire, if_wins;

  function automatic logic [ST_W-1:0] streak_sat_inc(input logic [ST_W-1:0] v);
    return (v == ST_MAX) ? v : v + ST_W'(1);
  endfunction

  // A requester whose ready pulse is high is still showing the old request.
  assign if_elig   = bus_io.if_req & ~if_ready_q;
  assign ma_elig   = bus_io.ma_req & ~ma_ready_q;
  assign if_wins   = if_elig & (~ma_elig | (streak_q == ST_MAX));
  assign wd_expire = WD_EN && (wdog_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_ready_d  = 1'b0;
    ma_ready_d  = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ma_rdata_d  = ma_rdata_q;
    streak_d    = streak_q;
    wdog_d      = wdog_q;

    case (state_q)
      IDLE: begin
        if (if_wins) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus_io.if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = 4'b0000;
          streak_d    = '0;
          wdog_d      = '0;
        end else if (ma_elig) begin
          state_d     = BUSY_MA;
          mem_req_d   = 1'b1;
          mem_we_d    = bus_io.ma_we;
          mem_addr_d  = bus_io.ma_addr;
          mem_wdata_d = bus_io.ma_wdata;
          mem_wstrb_d = bus_io.ma_we ? bus_io.ma_wstrb : 4'b0000;
          streak_d    = bus_io.if_req ? streak_sat_inc(streak_q) : '0;
          wdog_d      = '0;
        end
      end
      BUSY_IF, BUSY_MA: begin
        // A completion in the same cycle as the timeout wins over the abort.
        if (bus_io.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus_io.mem_rdata;
          end else begin
            ma_ready_d = 1'b1;
            ma_rdata_d = bus_io.mem_rdata;
          end
        end else if (wd_expire) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            ma_ready_d = 1'b1;
            ma_rdata_d = '0;
          end
        end else if (WD_EN) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ready_q  <= 1'b0;
      ma_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      ma_rdata_q  <= '0;
      streak_q    <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ready_q  <= if_ready_d;
      ma_ready_q  <= ma_ready_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      ma_rdata_q  <= ma_rdata_d;
      streak_q    <= streak_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus_io.mem_req   = mem_req_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_wstrb = mem_wstrb_q;
  assign bus_io.if_ready  = if_ready_q;
  assign bus_io.if_rdata  = if_rdata_q;
  assign bus_io.ma_ready  = ma_ready_q;
  assign bus_io.ma_rdata  = ma_rdata_q;
  assign bus_io.bus_err   = bus_err_q;
  assign bus_io.stall_if  = bus_io.if_req & ~if_ready_q;
  assign bus_io.stall_ma  = bus_io.ma_req & ~ma_ready_q;
endmodule
